// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_scoreboard                                            |
// | Brief    : Architectural register file with one commit port, two         |
// |            combinational read ports with write-to-read bypass, and       |
// |            per-register pending-writer counters for RAW hazard detection.|
// | Ports    : clk, rst_n               clock, sync active-low reset          |
// |            rfWrite*_p0, done_in     commit port from writeback            |
// |            rfReadAddr/Data_p0/p1    decode source reads (combinational)   |
// |            issue_valid/wr/dest      decode issue of a register writer     |
// |            hazard_p0/p1             source has an unresolved writer       |
// |            issue_ready              issue can be accepted this cycle      |
// |            commit_count             commits since reset (wraps)           |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module regfile_scoreboard #(
    parameter int NREGS  = 32,  // addresses are 5 bits wide, so NREGS must be 32
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rfWriteData_p0,
    input  logic [4:0]        rfWriteAddr_p0,
    input  logic              rfWriteEn_p0,
    input  logic              done_in,
    input  logic [4:0]        rfReadAddr_p0,
    input  logic [4:0]        rfReadAddr_p1,
    output logic [DATA_W-1:0] rfReadData_p0,
    output logic [DATA_W-1:0] rfReadData_p1,
    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [4:0]        issue_dest,
    output logic              hazard_p0,
    output logic              hazard_p1,
    output logic              issue_ready,
    output logic [31:0]       commit_count
);

    localparam logic [PEND_W-1:0] c_CNT_MAX = '1;
    localparam logic [PEND_W-1:0] c_CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_cnt  [NREGS];
    logic [31:0]       r_commit_count;

    logic w_wr_fire;
    logic w_dec_fire;
    logic w_iss_req;
    logic w_iss_full;
    logic w_iss_ready;
    logic w_iss_fire;

    assign w_wr_fire = done_in & rfWriteEn_p0;

    // A commit retires one in-flight writer of its destination, if any exist.
    assign w_dec_fire = w_wr_fire && (rfWriteAddr_p0 != 5'd0) &&
                        (r_cnt[rfWriteAddr_p0] != '0);

    assign w_iss_req  = issue_valid && issue_wr && (issue_dest != 5'd0);

    // A saturated counter can still take a new writer if one retires this cycle.
    assign w_iss_full = (r_cnt[issue_dest] == c_CNT_MAX) &&
                        !(w_dec_fire && (rfWriteAddr_p0 == issue_dest));

    assign w_iss_ready = !(w_iss_req && w_iss_full);
    assign w_iss_fire  = w_iss_req && w_iss_ready;

    // Read ports: identical logic for both sources.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [4:0]        w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_hz;

        assign w_addr = (p == 0) ? rfReadAddr_p0 : rfReadAddr_p1;

        always_comb begin
            w_data = '0;
            w_hz   = 1'b0;
            if (rst_n && (w_addr != 5'd0)) begin
                if (w_wr_fire && (rfWriteAddr_p0 == w_addr)) begin
                    w_data = rfWriteData_p0;
                end else begin
                    w_data = r_regs[w_addr];
                end
                // The last pending writer committing now is served by the bypass.
                w_hz = (r_cnt[w_addr] != '0) &&
                       !(w_wr_fire && (rfWriteAddr_p0 == w_addr) &&
                         (r_cnt[w_addr] == c_CNT_ONE));
            end
        end
    end

    // Outputs present the reset state while reset is held.
    assign rfReadData_p0 = g_rd[0].w_data;
    assign rfReadData_p1 = g_rd[1].w_data;
    assign hazard_p0     = g_rd[0].w_hz;
    assign hazard_p1     = g_rd[1].w_hz;
    assign issue_ready   = rst_n ? w_iss_ready : 1'b1;
    assign commit_count  = rst_n ? r_commit_count : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit_count <= 32'd0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_wr_fire) begin
                r_commit_count <= r_commit_count + 32'd1;
                if (rfWriteAddr_p0 != 5'd0) begin
                    r_regs[rfWriteAddr_p0] <= rfWriteData_p0;
                end
            end
            // An issue and a retirement on the same register cancel out.
            for (int i = 0; i < NREGS; i++) begin
                if (w_iss_fire && (issue_dest == 5'(i)) &&
                    !(w_dec_fire && (rfWriteAddr_p0 == 5'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end else if (w_dec_fire && (rfWriteAddr_p0 == 5'(i)) &&
                             !(w_iss_fire && (issue_dest == 5'(i)))) begin
                    r_cnt[i] <= r_cnt[i] - c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_scoreboard                                         |
// | Brief    : Directed stimulus for regfile_scoreboard with a reference     |
// |            model compared on every negedge plus literal spot checks.     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_regfile_scoreboard;

    localparam int c_MAXCNT = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] rfWriteData_p0;
    logic [4:0]  rfWriteAddr_p0;
    logic        rfWriteEn_p0;
    logic        done_in;
    logic [4:0]  rfReadAddr_p0;
    logic [4:0]  rfReadAddr_p1;
    logic [31:0] rfReadData_p0;
    logic [31:0] rfReadData_p1;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_dest;
    logic        hazard_p0;
    logic        hazard_p1;
    logic        issue_ready;
    logic [31:0] commit_count;

    int tests;
    int fails;

    regfile_scoreboard #(.NREGS(32), .DATA_W(32), .PEND_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rfWriteData_p0 (rfWriteData_p0),
        .rfWriteAddr_p0 (rfWriteAddr_p0),
        .rfWriteEn_p0   (rfWriteEn_p0),
        .done_in        (done_in),
        .rfReadAddr_p0  (rfReadAddr_p0),
        .rfReadAddr_p1  (rfReadAddr_p1),
        .rfReadData_p0  (rfReadData_p0),
        .rfReadData_p1  (rfReadData_p1),
        .issue_valid    (issue_valid),
        .issue_wr       (issue_wr),
        .issue_dest     (issue_dest),
        .hazard_p0      (hazard_p0),
        .hazard_p1      (hazard_p1),
        .issue_ready    (issue_ready),
        .commit_count   (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic [31:0] m_cc;
    bit          m_valid = 1'b0;

    function automatic bit m_commit();
        return done_in && rfWriteEn_p0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (m_commit() && rfWriteAddr_p0 == a) return rfWriteData_p0;
        return m_regs[a];
    endfunction

    function automatic bit m_hazard(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 1'b0;
        if (m_cnt[a] == 0) return 1'b0;
        if (m_commit() && rfWriteAddr_p0 == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_retires(input logic [4:0] a);
        return m_commit() && rfWriteAddr_p0 == a && a != 5'd0 && m_cnt[a] > 0;
    endfunction

    function automatic bit m_ready();
        if (!rst_n) return 1'b1;
        if (issue_valid && issue_wr && issue_dest != 5'd0 &&
            m_cnt[issue_dest] == c_MAXCNT && !m_retires(issue_dest)) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_cnt[i]  = 0;
            end
            m_cc    = 32'd0;
            m_valid = 1'b1;
        end else begin
            bit          inc;
            bit          dec;
            logic [4:0]  wa;
            logic [4:0]  d;
            wa  = rfWriteAddr_p0;
            d   = issue_dest;
            dec = m_retires(wa);
            inc = issue_valid && issue_wr && d != 5'd0 && m_ready();
            if (m_commit()) begin
                m_cc = m_cc + 32'd1;
                if (wa != 5'd0) m_regs[wa] = rfWriteData_p0;
            end
            if (inc) m_cnt[d] = m_cnt[d] + 1;
            if (dec) m_cnt[wa] = m_cnt[wa] - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_rd0",   rfReadData_p0,         m_read(rfReadAddr_p0));
            chk("cyc_rd1",   rfReadData_p1,         m_read(rfReadAddr_p1));
            chk("cyc_hz0",   32'(hazard_p0),        32'(m_hazard(rfReadAddr_p0)));
            chk("cyc_hz1",   32'(hazard_p1),        32'(m_hazard(rfReadAddr_p1)));
            chk("cyc_ready", 32'(issue_ready),      32'(m_ready()));
            chk("cyc_cc",    commit_count,          rst_n ? m_cc : 32'd0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rfWriteData_p0 = 32'd0;
        rfWriteAddr_p0 = 5'd0;
        rfWriteEn_p0   = 1'b0;
        done_in        = 1'b0;
        issue_valid    = 1'b0;
        issue_wr       = 1'b0;
        issue_dest     = 5'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] a, input logic [31:0] d);
        done_in        = 1'b1;
        rfWriteEn_p0   = 1'b1;
        rfWriteAddr_p0 = a;
        rfWriteData_p0 = d;
    endtask

    task automatic issue(input logic [4:0] d);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = d;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        rfReadAddr_p0 = 5'd0;
        rfReadAddr_p1 = 5'd0;
        idle();
        cyc();
        cyc();

        // 1: reset state
        rst_n = 1'b1;
        rfReadAddr_p0 = 5'd5;
        rfReadAddr_p1 = 5'd0;
        #1;
        chk("t1_rd_r5", rfReadData_p0, 32'd0);
        chk("t1_rd_r0", rfReadData_p1, 32'd0);
        chk("t1_hz0", 32'(hazard_p0), 32'd0);
        chk("t1_hz1", 32'(hazard_p1), 32'd0);
        chk("t1_ready", 32'(issue_ready), 32'd1);
        chk("t1_cc", commit_count, 32'd0);

        // 2: bypass on commit, then stored value
        cyc();
        commit(5'd3, 32'hDEADBEEF);
        rfReadAddr_p0 = 5'd3;
        rfReadAddr_p1 = 5'd3;
        #1;
        chk("t2_bypass", rfReadData_p0, 32'hDEADBEEF);
        chk("t2_bypass_p1", rfReadData_p1, 32'hDEADBEEF);
        cyc();
        idle();
        #1;
        chk("t2_stored", rfReadData_p0, 32'hDEADBEEF);
        chk("t2_cc", commit_count, 32'd1);

        // 3: r0 commit ignored for data but counted; done_in gates the commit
        commit(5'd0, 32'h1234);
        rfReadAddr_p0 = 5'd0;
        cyc();
        idle();
        #1;
        chk("t3_r0", rfReadData_p0, 32'd0);
        chk("t3_cc", commit_count, 32'd2);
        rfWriteEn_p0   = 1'b1;
        rfWriteAddr_p0 = 5'd7;
        rfWriteData_p0 = 32'h55;
        rfReadAddr_p1  = 5'd7;
        #1;
        chk("t3_nodone_bypass", rfReadData_p1, 32'd0);
        cyc();
        idle();
        #1;
        chk("t3_r7", rfReadData_p1, 32'd0);
        chk("t3_cc_nodone", commit_count, 32'd2);

        // 4: single writer hazard resolved by its own commit
        issue(5'd8);
        cyc();
        idle();
        rfReadAddr_p0 = 5'd8;
        #1;
        chk("t4_hz_set", 32'(hazard_p0), 32'd1);
        commit(5'd8, 32'hA5);
        #1;
        chk("t4_hz_resolve", 32'(hazard_p0), 32'd0);
        chk("t4_bypass", rfReadData_p0, 32'hA5);
        cyc();
        idle();
        #1;
        chk("t4_model_cnt8", 32'(m_cnt[8]), 32'd0);
        chk("t4_hz_after", 32'(hazard_p0), 32'd0);

        // 5: counter saturation stalls issue unless a writer retires
        for (int k = 0; k < 3; k++) begin
            issue(5'd9);
            cyc();
        end
        idle();
        issue(5'd9);
        rfReadAddr_p0 = 5'd9;
        #1;
        chk("t5_stall", 32'(issue_ready), 32'd0);
        chk("t5_hz", 32'(hazard_p0), 32'd1);
        cyc();
        chk("t5_model_cnt9", 32'(m_cnt[9]), 32'd3);
        commit(5'd9, 32'h99);
        #1;
        chk("t5_ready_with_retire", 32'(issue_ready), 32'd1);
        cyc();
        idle();
        #1;
        chk("t5_model_cnt9_after", 32'(m_cnt[9]), 32'd3);
        chk("t5_hz_after", 32'(hazard_p0), 32'd1);
        chk("t5_data", rfReadData_p0, 32'h99);
        // drain r9 and check the counter does not underflow
        for (int k = 0; k < 4; k++) begin
            commit(5'd9, 32'h100 + 32'(k));
            cyc();
        end
        idle();
        #1;
        chk("t5_drained_hz", 32'(hazard_p0), 32'd0);
        chk("t5_model_cnt9_zero", 32'(m_cnt[9]), 32'd0);

        // 6: same-register issue and retire cancel; reset clears everything
        issue(5'd4);
        cyc();
        idle();
        issue(5'd4);
        commit(5'd4, 32'h44);
        rfReadAddr_p0 = 5'd4;
        rfReadAddr_p1 = 5'd4;
        #1;
        chk("t6_hz_same_cycle", 32'(hazard_p0), 32'd0);
        cyc();
        idle();
        #1;
        chk("t6_hz_persist", 32'(hazard_p0), 32'd1);
        chk("t6_hz_persist_p1", 32'(hazard_p1), 32'd1);
        chk("t6_model_cnt4", 32'(m_cnt[4]), 32'd1);
        chk("t6_data", rfReadData_p0, 32'h44);
        rst_n = 1'b0;
        issue(5'd4);
        commit(5'd4, 32'h77);
        #1;
        chk("t6_rst_rd", rfReadData_p0, 32'd0);
        chk("t6_rst_hz", 32'(hazard_p0), 32'd0);
        chk("t6_rst_ready", 32'(issue_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        idle();
        rfReadAddr_p1 = 5'd3;
        #1;
        chk("t6_post_rd", rfReadData_p0, 32'd0);
        chk("t6_post_hz", 32'(hazard_p0), 32'd0);
        chk("t6_post_r3", rfReadData_p1, 32'd0);
        chk("t6_post_cc", commit_count, 32'd0);
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
